// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding data-memory access, lane shifting and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN adds a misaligned-access trap and the misalign_o port.
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [3:0]        mem_write_mask_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  output logic [1:0]        dbg_state_o
);

  // Handshake: dmem_req_o is held with stable addr/we/be/wdata until a cycle
  // where dmem_gnt_i is high; a load then waits for one dmem_rvalid_i pulse.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          mask_q, mask_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                we_q, we_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                accept;
  logic                mis_in;
  logic [31:0]         shifted;
  logic [31:0]         load_result;

  assign accept = (state_q == S_IDLE) && req_valid_i && (mem_read_i || mem_write_i);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  logic is_half;
  logic is_word;

  // Stores are sized by their lane mask, loads by funct3.
  assign is_half = mem_write_i ? (mem_write_mask_i == 4'b0011) : (funct3_i[1:0] == 2'b01);
  assign is_word = mem_write_i ? (mem_write_mask_i == 4'b1111) : (funct3_i == 3'b010);
  assign mis_in  = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= accept && mis_in;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign mis_in = 1'b0;
`endif

  assign shifted = dmem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_result = 32'h0;
    case (funct3_q)
      3'b000:  load_result = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_result = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_result = dmem_rdata_i;
      3'b100:  load_result = {24'h0, shifted[7:0]};
      3'b101:  load_result = {16'h0, shifted[15:0]};
      default: load_result = 32'h0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          mask_d   = mem_write_mask_i;
          funct3_d = funct3_i;
          we_d     = mem_write_i;
          state_d  = mis_in ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (dmem_gnt_i) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          rdata_d = load_result;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      mask_q   <= 4'h0;
      funct3_q <= 3'h0;
      we_q     <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign rdata_o      = rdata_q;
  assign dmem_req_o   = (state_q == S_REQ);
  assign dmem_we_o    = (state_q == S_REQ) && we_q;
  // Lanes shifted past byte 3 are dropped by the 4-bit result width.
  assign dmem_be_o    = ((state_q == S_REQ) && we_q) ? (mask_q << addr_q[1:0]) : 4'h0;
  assign dmem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem_wdata_o = wdata_q << {addr_q[1:0], 3'b000};
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized loads/stores
// checked against a behavioural model of addressing, lane shifting, extension and timing.
module tb_lsu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, mem_read_i, mem_write_i;
  logic [3:0]  mem_write_mask_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o;
  logic [31:0] rdata_o;
  logic        dmem_req_o, dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [1:0]  dbg_state_o;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_o;
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_bad    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_write_mask_i(mem_write_mask_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign_o(misalign_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (8 * off)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd2:    return word;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_misaligned(input bit store, input logic [3:0] mask,
                                          input logic [2:0] f3, input logic [1:0] off);
    int size_bytes;
    if (store) size_bytes = (mask == 4'b1111) ? 4 : (mask == 4'b0011) ? 2 : 1;
    else       size_bytes = (f3 == 3'd2) ? 4 : (f3[1:0] == 2'b01) ? 2 : 1;
    return (int'(off) % size_bytes) != 0;
  endfunction

  task automatic idle_inputs();
    req_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    mem_write_mask_i = 4'h0; funct3_i = 3'h0; addr_i = 32'h0; wdata_i = 32'h0;
  endtask

  // Random requests presented while busy must be ignored.
  task automatic busy_noise();
    req_valid_i = 1'($urandom_range(0, 1));
    mem_read_i  = 1'b1;
    mem_write_i = 1'($urandom_range(0, 1));
    mem_write_mask_i = 4'hF;
    funct3_i = 3'($urandom_range(0, 7));
    addr_i   = $urandom;
    wdata_i  = $urandom;
  endtask

  // driver: one full transaction, entered and left at a negedge with the DUT idle
  task automatic run_txn(input bit rd, input bit wr, input logic [3:0] mask,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gd, input int rvd,
                         input logic [31:0] rword, input string tag);
    bit          st, mis;
    logic [1:0]  off;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    st      = wr;
    off     = addr[1:0];
    e_addr  = addr & 32'hFFFF_FFFC;
    e_be    = st ? 4'((int'(mask) << off) & 15) : 4'h0;
    e_wdata = wdata << (8 * off);
    mis     = TRAP_EN && model_misaligned(st, mask, f3, off);
    if (!st && !mis) exp_q.push_back(model_load(f3, off, rword));

    req_valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
    mem_write_mask_i = mask; funct3_i = f3; addr_i = addr; wdata_i = wdata;
    @(negedge clk_i);
    if (!mis) begin
      for (int k = 0; k <= gd; k++) begin
        check_val({tag, ".req"},   dmem_req_o, 1);
        check_val({tag, ".addr"},  dmem_addr_o, e_addr);
        check_val({tag, ".be"},    dmem_be_o, e_be);
        check_val({tag, ".we"},    dmem_we_o, st);
        if (st) check_val({tag, ".wdata"}, dmem_wdata_o, e_wdata);
        check_val({tag, ".early_done"}, done_o, 0);
        dmem_gnt_i = (k == gd);
        busy_noise();
        @(negedge clk_i);
      end
      dmem_gnt_i = 1'b0;
      if (!st) begin
        for (int k = 0; k <= rvd; k++) begin
          check_val({tag, ".wait_req"},  dmem_req_o, 0);
          check_val({tag, ".wait_be"},   dmem_be_o, 0);
          check_val({tag, ".wait_done"}, done_o, 0);
          check_val({tag, ".wait_busy"}, busy_o, 1);
          dmem_rvalid_i = (k == rvd);
          dmem_rdata_i  = (k == rvd) ? rword : $urandom;
          busy_noise();
          @(negedge clk_i);
        end
        dmem_rvalid_i = 1'b0;
        last_rdata = exp_q.pop_front();
      end
    end
    idle_inputs();
    check_val({tag, ".done"},     done_o, 1);
    check_val({tag, ".busy"},     busy_o, 1);
    check_val({tag, ".done_req"}, dmem_req_o, 0);
    check_val({tag, ".rdata"},    rdata_o, last_rdata);
`ifdef LSU_MISALIGN_TRAP_EN
    check_val({tag, ".misalign"}, misalign_o, mis);
`endif
    @(negedge clk_i);
    check_val({tag, ".done_pulse"}, done_o, 0);
    check_val({tag, ".idle"},       busy_o, 0);
    check_val({tag, ".idle_req"},   dmem_req_o, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".busy"},  busy_o, 0);
    check_val({tag, ".done"},  done_o, 0);
    check_val({tag, ".req"},   dmem_req_o, 0);
    check_val({tag, ".we"},    dmem_we_o, 0);
    check_val({tag, ".be"},    dmem_be_o, 0);
    check_val({tag, ".addr"},  dmem_addr_o, 0);
    check_val({tag, ".wdata"}, dmem_wdata_o, 0);
    check_val({tag, ".rdata"}, rdata_o, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check_val({tag, ".misalign"}, misalign_o, 0);
`endif
  endtask

  task automatic random_txn(input int idx);
    bit          rd, wr;
    logic [3:0]  mask;
    logic [2:0]  f3;
    int          sel;
    sel  = $urandom_range(0, 1);
    f3   = 3'($urandom_range(0, 7));
    mask = 4'h0;
    if (sel == 1) begin
      wr = 1'b1;
      rd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       mask = 4'b0001;
        1:       mask = 4'b0011;
        default: mask = 4'b1111;
      endcase
    end else begin
      wr = 1'b0;
      rd = 1'b1;
    end
    run_txn(rd, wr, mask, f3, $urandom, $urandom, $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom, $sformatf("rnd%0d", idx));
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    last_rdata = 32'h0;
    #2;
    check_reset_outputs("por");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("post_rst");

    run_txn(0, 1, 4'b1111, 3'd2, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0, "sw_100");
    run_txn(0, 1, 4'b0001, 3'd0, 32'h103, 32'h0000_00A5, 0, 0, 32'h0, "sb_103");
    run_txn(1, 0, 4'b0000, 3'd0, 32'h102, 32'h0, 3, 0, 32'h0080_0000, "lb_102");
    run_txn(1, 0, 4'b0000, 3'd4, 32'h102, 32'h0, 3, 1, 32'h0080_0000, "lbu_102");
    run_txn(1, 0, 4'b0000, 3'd1, 32'h101, 32'h0, 0, 0, 32'h00AB_CD00, "lh_101");
    run_txn(1, 1, 4'b0011, 3'd1, 32'h202, 32'h1234_5678, 1, 0, 32'h0, "both_sh");
    run_txn(1, 0, 4'b0000, 3'd5, 32'h206, 32'h0, 0, 2, 32'h9ABC_0000, "lhu_206");
    run_txn(1, 0, 4'b0000, 3'd7, 32'h300, 32'h0, 0, 0, 32'hFFFF_FFFF, "bad_f3");

    // req_valid with neither direction is ignored
    req_valid_i = 1'b1; addr_i = 32'h400;
    @(negedge clk_i);
    check_val("nop.busy", busy_o, 0);
    check_val("nop.req",  dmem_req_o, 0);
    idle_inputs();
    @(negedge clk_i);
    check_val("nop.busy2", busy_o, 0);

    for (int i = 0; i < 200; i++) random_txn(i);

    // load a known nonzero value, then reset mid-WAIT
    run_txn(1, 0, 4'b0000, 3'd2, 32'h500, 32'h0, 0, 0, 32'hCAFE_F00D, "lw_500");
    req_valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h600;
    @(negedge clk_i);
    idle_inputs();
    check_val("rstw.req", dmem_req_o, 1);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    check_val("rstw.busy", busy_o, 1);
    check_val("rstw.req0", dmem_req_o, 0);
    #2 rst_ni = 1'b0;
    #1;
    check_reset_outputs("rstw.async");
    @(negedge clk_i);
    rst_ni = 1'b1;
    last_rdata = 32'h0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    check_val("rstw.late_done",  done_o, 0);
    check_val("rstw.late_busy",  busy_o, 0);
    check_val("rstw.late_rdata", rdata_o, 0);
    @(negedge clk_i);
    check_val("rstw.late_done2", done_o, 0);

    for (int i = 200; i < 260; i++) random_txn(i);
    check_val("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
